// File: rtl/alu_operand_stage.sv
// Operand decode/issue stage in front of the 16-bit ALU: decode, EX/WB operand bypass,
// one-entry skid buffer and self-hazard stall. Optional macro FORWARD_EN enables the bypass.
module alu_operand_stage #(
  parameter int IMM_W   = 6,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [1:0]         funct,
  input  logic [RADDR_W-1:0] rs,
  input  logic [RADDR_W-1:0] rt,
  input  logic [RADDR_W-1:0] rd,
  input  logic [IMM_W-1:0]   imm,
  input  logic [15:0]        rs_data,
  input  logic [15:0]        rt_data,
  input  logic               ex_wen,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic [15:0]        ex_data,
  input  logic               wb_wen,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [15:0]        wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        A,
  output logic [15:0]        B,
  output logic               AInvert,
  output logic [3:0]         Op,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_wen,
  output logic               out_illegal
);

  localparam int EXT_W = 16 - IMM_W;

  typedef struct packed {
    logic [15:0]        a;
    logic [15:0]        b;
    logic               ainv;
    logic [3:0]         op;
    logic [RADDR_W-1:0] rd;
    logic               wen;
    logic               ill;
  } entry_t;

  typedef enum logic [1:0] {BSEL_RT, BSEL_SEXT, BSEL_ZEXT} bsel_e;

  entry_t out_q, out_d, skid_q, skid_d, dec;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   use_rs, use_rt, hazard, accept, consume;
  bsel_e  bsel;

  function automatic logic [15:0] resolve(input logic [RADDR_W-1:0] idx,
                                          input logic [15:0] rf);
    logic [15:0] val;
    val = rf;
`ifdef FORWARD_EN
    if (ex_wen && ex_rd == idx)
      val = ex_data;
    else if (wb_wen && wb_rd == idx)
      val = wb_data;
`endif
    if (idx == '0)
      val = '0;
    return val;
  endfunction

  function automatic logic src_hit(input logic en, input logic [RADDR_W-1:0] idx,
                                   input logic wr, input logic [RADDR_W-1:0] dst);
    return en && (idx != '0) && wr && (dst == idx);
  endfunction

`ifdef FORWARD_EN
`else
  logic unused_fwd_data;
  assign unused_fwd_data = ^{ex_data, wb_data};
`endif

  always_comb begin
    dec    = '0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    bsel   = BSEL_RT;
    dec.rd = rd;
    case (opcode)
      4'b0000: begin
        use_rs  = 1'b1;
        use_rt  = 1'b1;
        dec.wen = 1'b1;
        case (funct)
          2'b00:   dec.op = 4'b0100;
          2'b01:   dec.op = 4'b1100;
          2'b10:   dec.op = 4'b0000;
          default: dec.op = 4'b0010;
        endcase
      end
      4'b0001: begin use_rs = 1'b1; use_rt = 1'b1; dec.wen = 1'b1; dec.op = 4'b0001; end
      4'b0010: begin use_rs = 1'b1; bsel = BSEL_SEXT; dec.wen = 1'b1; dec.op = 4'b0100; end
      4'b0011: begin use_rs = 1'b1; bsel = BSEL_ZEXT; dec.wen = 1'b1; dec.op = 4'b0000; end
      4'b0100: begin use_rs = 1'b1; bsel = BSEL_ZEXT; dec.wen = 1'b1; dec.op = 4'b0010; end
      4'b0101: begin use_rs = 1'b1; bsel = BSEL_SEXT; dec.wen = 1'b1; dec.op = 4'b0001; end
      4'b0111: begin
        use_rs   = 1'b1;
        use_rt   = 1'b1;
        dec.wen  = 1'b1;
        dec.op   = 4'b1000;
        dec.ainv = 1'b1;
      end
      default: dec.ill = 1'b1;
    endcase
    // Illegal opcodes read no sources, so they never stall and carry zero operands.
    if (use_rs)
      dec.a = resolve(rs, rs_data);
    case (bsel)
      BSEL_SEXT: dec.b = {{EXT_W{imm[IMM_W-1]}}, imm};
      BSEL_ZEXT: dec.b = {{EXT_W{1'b0}}, imm};
      default:   dec.b = use_rt ? resolve(rt, rt_data) : 16'h0000;
    endcase
  end

  always_comb begin
    hazard = src_hit(use_rs, rs, out_valid_q & out_q.wen, out_q.rd)
           | src_hit(use_rt, rt, out_valid_q & out_q.wen, out_q.rd)
           | src_hit(use_rs, rs, skid_valid_q & skid_q.wen, skid_q.rd)
           | src_hit(use_rt, rt, skid_valid_q & skid_q.wen, skid_q.rd);
`ifdef FORWARD_EN
`else
    // Without the bypass, wait until in-flight producers have retired to the register file.
    hazard = hazard
           | src_hit(use_rs, rs, ex_wen, ex_rd) | src_hit(use_rt, rt, ex_wen, ex_rd)
           | src_hit(use_rs, rs, wb_wen, wb_rd) | src_hit(use_rt, rt, wb_wen, wb_rd);
`endif
  end

  assign accept  = in_valid & in_ready_q & ~hazard;
  assign consume = out_valid_q & out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || consume) begin
      // in_ready_q is low whenever the skid holds an entry, so drain and accept never collide.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign A           = out_q.a;
  assign B           = out_q.b;
  assign AInvert     = out_q.ainv;
  assign Op          = out_q.op;
  assign out_rd      = out_q.rd;
  assign out_wen     = out_q.wen;
  assign out_illegal = out_q.ill;

endmodule
